freq_meas_seq: RTL and testbench
================================

# freq_meas_seq

Measurement sequencer for the digital frequency meter: generates the counter clear, the synchronized gate window, the store strobe and the 2-bit status word consumed by the gated period/reference counters. Implements the equal-precision method: the gate opens and closes only on rising edges of the measured signal, after a preset minimum gate time on the system clock. It is the initiator side of the counter control interface; the counters only respond to it.

## Interface
- GATE_CYCLES, 50_000_000: preset gate time in clk cycles, ≥ 2
- CLR_CYCLES, 4: length of clear_n low pulse in clk cycles, ≥ 1
- HOLD_CYCLES, 25_000_000: display hold after store, ≥ 1
- TIMEOUT_CYCLES, 100_000_000: max wait for a sig_in edge in ARM or CLOSE, > GATE_CYCLES
- clk  in  1  system/reference clock, all logic on posedge
- nRST  in  1  reset nRST, asynchronous, active-low
- run  in  1  level; high = continuous measurement cycles, low = finish current cycle then idle
- sig_in  in  1  measured signal, asynchronous to clk
- clear_n  out  1  active-low counter clear
- gate  out  1  measurement window enable to counters
- store  out  1  one-cycle strobe: counters’ values are final
- status  out  2  00 IDLE, 01 CLEAR, 11 ARMED/GATING (counting allowed), 10 STORE/HOLD
- valid  out  1  last stored result is a real measurement (no timeout)
- timeout  out  1  sticky per cycle: last cycle aborted for missing sig_in edge

## Operation
- sig_in passes a 2-FF synchronizer then a rising-edge detector; `sig_rise` is one clk wide.
- States: IDLE, CLEAR, ARM, GATE, CLOSE, STORE, HOLD.
- IDLE: status 00, clear_n 1, gate 0. run=1 -> CLEAR.
- CLEAR: clear_n 0 for exactly CLR_CYCLES cycles, status 01 -> ARM.
- ARM: status 11, timeout timer runs. sig_rise -> GATE (gate 1 from next cycle). Timer reaches TIMEOUT_CYCLES -> STORE with timeout=1, valid=0.
- GATE: gate 1, preset timer counts clk cycles; on count GATE_CYCLES-1 -> CLOSE. sig_rise during GATE ignored.
- CLOSE: gate stays 1, timeout timer restarts; sig_rise -> STORE, gate 0 from next cycle. Timeout -> STORE, gate 0, timeout=1, valid=0.
- STORE: one cycle, store=1, status 10; if no timeout, valid=1, timeout=0.
- HOLD: status 10 for HOLD_CYCLES; then run=1 -> CLEAR, run=0 -> IDLE.
- run deasserted mid-cycle does not abort; sequence completes through HOLD.
- Timers: single down/up counter width $clog2(max parameter)+1, reloaded on every state entry; no wrap possible because each state exits at its terminal count.
- nRST low at any time: immediately IDLE, clear_n 1, gate 0, store 0, status 00, valid 0, timeout 0, synchronizer flops 0.

## Timing
- Reset values: clear_n 1, gate 0, store 0, status 00, valid 0, timeout 0.
- sig_in rise to sig_rise: 2–3 clk (synchronizer); sig_rise to gate edge: 1 clk (registered outputs).
- Gate high time = GATE_CYCLES + wait to next qualifying edge, always integer sig_in periods.
- status changes to 11 in the first ARM cycle, ≥1 clk before gate rises, so counters see 11 at gate posedge.
- store is asserted the cycle after gate falls; never coincident with gate=1 or clear_n=0.
- All outputs registered; no combinational path from sig_in.
- sig_rise coincident with preset terminal count in GATE: ignored; gate closes on the next sig_rise in CLOSE.

## Structure
- Package freq_meter_pkg: state enum, status codes (ST_IDLE=00, ST_CLEAR=01, ST_RUN=11, ST_HOLD=10).
- Sub-module sig_sync: 2-FF synchronizer plus rising-edge detector, async nRST clear; reused by other meter inputs.
- Top holds FSM, shared timer, output registers.

## Test plan
- Params GATE=100, CLR=4, HOLD=8, TIMEOUT=400; sig_in period 30 clk, run=1 -> clear_n low 4 cycles, gate high 120 clk (4 sig periods), store one pulse after gate falls, valid=1.
- sig_in constant 0, run=1 -> status 11 for 400 cycles, gate never rises, store pulse, timeout=1, valid=0.
- sig_in stops after gate opens -> CLOSE times out after 400 cycles, gate falls, timeout=1, valid=0.
- run pulled low during GATE -> cycle completes through HOLD, then IDLE, status 00, no new clear_n.
- nRST asserted mid-GATE -> same cycle gate=0, status=00, all outputs at reset values; release with run=1 -> fresh CLEAR.
- sig_rise on preset terminal-count cycle (sig period exactly 100) -> gate length 200 clk, not 100.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types for the frequency meter: sequencer states, status codes
// seen by the gated counters, and small elaboration helpers.
`timescale 1ns/1ps
package freq_meter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_GATE,
        S_CLOSE,
        S_STORE,
        S_HOLD
    } state_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CLEAR = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b11;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // ARM/GATE/CLOSE all report "counting allowed" so the counters already
    // see 11 before the gate edge arrives.
    function automatic logic [1:0] status_of(input state_t s);
        logic [1:0] code;
        code = ST_IDLE;
        case (s)
            S_IDLE:                  code = ST_IDLE;
            S_CLEAR:                 code = ST_CLEAR;
            S_ARM, S_GATE, S_CLOSE:  code = ST_RUN;
            S_STORE, S_HOLD:         code = ST_HOLD;
            default:                 code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sig_sync.sv
// Two-flop synchronizer for an asynchronous meter input followed by a
// registered-history rising-edge detector; rise is one clk wide.
`timescale 1ns/1ps
module sig_sync (
    input  logic clk,
    input  logic nRST,
    input  logic din,
    output logic rise
);

    logic [2:0] shift;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            shift <= '0;
        end else begin
            shift <= {shift[1:0], din};
        end
    end

    assign rise = shift[1] & ~shift[2];

endmodule

// File: rtl/freq_meas_seq.sv
// Equal-precision measurement sequencer: drives counter clear, gate window
// aligned to sig_in rising edges, store strobe and status word.
`timescale 1ns/1ps
module freq_meas_seq
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned CLR_CYCLES     = 4,
    parameter int unsigned HOLD_CYCLES    = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       run,
    input  logic       sig_in,
    output logic       clear_n,
    output logic       gate,
    output logic       store,
    output logic [1:0] status,
    output logic       valid,
    output logic       timeout
);

    localparam int unsigned MAX_P = max_u(max_u(GATE_CYCLES, CLR_CYCLES),
                                          max_u(HOLD_CYCLES, TIMEOUT_CYCLES));
    localparam int unsigned TW = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] CLR_LAST  = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("GATE_CYCLES must be at least 2");
    end
    if (CLR_CYCLES < 1) begin : g_bad_clr
        $error("CLR_CYCLES must be at least 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES <= GATE_CYCLES) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must exceed GATE_CYCLES");
    end

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic          sig_rise;
    logic          abort_nx;

    sig_sync u_sig_sync (
        .clk  (clk),
        .nRST (nRST),
        .din  (sig_in),
        .rise (sig_rise)
    );

    always_comb begin
        state_nx = state;
        abort_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                if (timer == CLR_LAST) state_nx = S_ARM;
            end
            S_ARM: begin
                if (sig_rise) begin
                    state_nx = S_GATE;
                end else if (timer == TMO_LAST) begin
                    state_nx = S_STORE;
                    abort_nx = 1'b1;
                end
            end
            // Edges inside the preset window, including its last cycle, never close it.
            S_GATE: begin
                if (timer == GATE_LAST) state_nx = S_CLOSE;
            end
            S_CLOSE: begin
                if (sig_rise) begin
                    state_nx = S_STORE;
                end else if (timer == TMO_LAST) begin
                    state_nx = S_STORE;
                    abort_nx = 1'b1;
                end
            end
            S_STORE: begin
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (timer == HOLD_LAST) state_nx = run ? S_CLEAR : S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            timer   <= '0;
            clear_n <= 1'b1;
            gate    <= 1'b0;
            store   <= 1'b0;
            status  <= ST_IDLE;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_nx;
            // Outputs are registered from the next state so they line up with it.
            if (state_nx != state || state_nx == S_IDLE) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            clear_n <= (state_nx != S_CLEAR);
            gate    <= (state_nx == S_GATE) || (state_nx == S_CLOSE);
            store   <= (state_nx == S_STORE);
            status  <= status_of(state_nx);
            if (state_nx == S_STORE) begin
                valid   <= ~abort_nx;
                timeout <= abort_nx;
            end
        end
    end

endmodule

// File: tb/tb_freq_meas_seq.sv
// Directed bench for freq_meas_seq: a procedural phase model predicts every
// output each cycle; literal gate/clear/arm lengths pin that model.
`timescale 1ns/1ps
module tb_freq_meas_seq;

    localparam int unsigned GATE = 100;
    localparam int unsigned CLR  = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned TMO  = 400;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       run = 1'b0;
    logic       sig_in = 1'b0;
    logic       clear_n;
    logic       gate;
    logic       store;
    logic [1:0] status;
    logic       valid;
    logic       timeout;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    freq_meas_seq #(
        .GATE_CYCLES    (GATE),
        .CLR_CYCLES     (CLR),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .nRST    (nRST),
        .run     (run),
        .sig_in  (sig_in),
        .clear_n (clear_n),
        .gate    (gate),
        .store   (store),
        .status  (status),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Measured signal: 50% duty square wave of sig_per clk cycles, 0 when sig_per==0.
    int unsigned sig_per = 0;
    int unsigned sig_ph = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (sig_per == 0) begin
                sig_in = 1'b0;
                sig_ph = 0;
            end else begin
                sig_in = (sig_ph < sig_per / 2);
                sig_ph = (sig_ph + 1) % sig_per;
            end
        end
    end

    // Expected outputs after the latest rising clock edge.
    logic       e_clear_n = 1'b1;
    logic       e_gate = 1'b0;
    logic       e_store = 1'b0;
    logic [1:0] e_status = 2'b00;
    logic       e_valid = 1'b0;
    logic       e_timeout = 1'b0;
    bit         rst_seen = 1'b1;
    bit         m_rise;
    bit         m_run;
    logic       s1m = 1'b0, s2m = 1'b0, s3m = 1'b0;

    always @(negedge nRST) rst_seen = 1'b1;

    task automatic tick();
        @(posedge clk);
        m_rise = s2m & ~s3m;
        s3m = s2m;
        s2m = s1m;
        s1m = sig_in;
        m_run = run;
    endtask

    task automatic expect_out(input logic cn, input logic g, input logic st, input logic [1:0] stat);
        e_clear_n = cn;
        e_gate = g;
        e_store = st;
        e_status = stat;
    endtask

    task automatic model_cycle();
        bit more = 1'b1;
        bit hit;
        bit aborted;
        while (more) begin
            expect_out(1'b0, 1'b0, 1'b0, 2'b01);
            repeat (CLR) begin tick(); if (rst_seen) return; end
            expect_out(1'b1, 1'b0, 1'b0, 2'b11);
            hit = 1'b0;
            for (int unsigned j = 0; j < TMO && !hit; j++) begin
                tick(); if (rst_seen) return;
                hit = m_rise;
            end
            aborted = !hit;
            if (hit) begin
                expect_out(1'b1, 1'b1, 1'b0, 2'b11);
                repeat (GATE) begin tick(); if (rst_seen) return; end
                hit = 1'b0;
                for (int unsigned j = 0; j < TMO && !hit; j++) begin
                    tick(); if (rst_seen) return;
                    hit = m_rise;
                end
                aborted = !hit;
            end
            expect_out(1'b1, 1'b0, 1'b1, 2'b10);
            e_valid = !aborted;
            e_timeout = aborted;
            tick(); if (rst_seen) return;
            expect_out(1'b1, 1'b0, 1'b0, 2'b10);
            repeat (HOLD) begin tick(); if (rst_seen) return; end
            more = m_run;
        end
        expect_out(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        forever begin
            if (rst_seen) begin
                expect_out(1'b1, 1'b0, 1'b0, 2'b00);
                e_valid = 1'b0;
                e_timeout = 1'b0;
                s1m = 1'b0; s2m = 1'b0; s3m = 1'b0;
                wait (nRST === 1'b1);
                rst_seen = 1'b0;
            end
            tick();
            if (rst_seen) continue;
            if (m_run) model_cycle();
        end
    end

    // Per-cycle compare plus pulse-length monitors.
    int unsigned gate_cur = 0, gate_len = 0, gate_rises = 0;
    int unsigned clr_cur = 0, clr_len = 0, clr_pulses = 0;
    int unsigned arm_cur = 0, arm_len = 0;
    logic        gate_prev = 1'b0;

    always @(negedge clk) begin
        if (!nRST) begin
            check("reset_outputs", 32'({clear_n, gate, store, status, valid, timeout}), 32'b1000000);
            gate_cur = 0; clr_cur = 0; arm_cur = 0; gate_prev = 1'b0;
        end else begin
            check("outputs", 32'({clear_n, gate, store, status, valid, timeout}),
                  32'({e_clear_n, e_gate, e_store, e_status, e_valid, e_timeout}));
            if (gate === 1'b1) gate_cur++;
            else if (gate_cur != 0) begin gate_len = gate_cur; gate_cur = 0; end
            if (gate === 1'b1 && gate_prev !== 1'b1) gate_rises++;
            gate_prev = gate;
            if (clear_n === 1'b0) clr_cur++;
            else if (clr_cur != 0) begin clr_len = clr_cur; clr_cur = 0; clr_pulses++; end
            if (status === 2'b11 && gate === 1'b0) arm_cur++;
            else if (arm_cur != 0) begin arm_len = arm_cur; arm_cur = 0; end
        end
    end

    // which: 0 gate high, 1 store high, 2 clear_n low
    task automatic wait_sig(input int unsigned which, input int unsigned budget, input string name);
        bit ok = 1'b0;
        for (int unsigned i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            case (which)
                0:       ok = (gate === 1'b1);
                1:       ok = (store === 1'b1);
                default: ok = (clear_n === 1'b0);
            endcase
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        int unsigned snap;
        nRST = 1'b0; run = 1'b0; sig_per = 30;
        repeat (3) @(negedge clk);
        #2 nRST = 1'b1;
        repeat (5) @(negedge clk);
        #1 check("idle_status", 32'(status), 32'd0);
        check("idle_clear_n", 32'(clear_n), 32'd1);

        // Normal cycle, run dropped during GATE: finishes, then idles.
        run = 1'b1;
        wait_sig(0, 200, "wait_gate_1");
        run = 1'b0;
        wait_sig(1, 700, "wait_store_1");
        check("gate_len_p30", 32'(gate_len), 32'd120);
        check("clear_len", 32'(clr_len), 32'd4);
        check("valid_1", 32'(valid), 32'd1);
        check("timeout_1", 32'(timeout), 32'd0);
        snap = clr_pulses;
        repeat (30) @(negedge clk);
        #1 check("idle_after_run_low", 32'(status), 32'd0);
        check("no_new_clear", 32'(clr_pulses), 32'(snap));

        // No edges at all: ARM times out.
        sig_per = 0;
        repeat (5) @(negedge clk);
        snap = gate_rises;
        pulse_run();
        wait_sig(1, 600, "wait_store_arm_tmo");
        check("arm_len", 32'(arm_len), 32'd400);
        check("gate_never_rose", 32'(gate_rises), 32'(snap));
        check("timeout_arm", 32'(timeout), 32'd1);
        check("valid_arm", 32'(valid), 32'd0);
        repeat (20) @(negedge clk);

        // Edges stop once the gate is open: CLOSE times out.
        sig_per = 30;
        pulse_run();
        wait_sig(0, 200, "wait_gate_3");
        sig_per = 0;
        wait_sig(1, 700, "wait_store_close_tmo");
        check("gate_len_close_tmo", 32'(gate_len), 32'd500);
        check("timeout_close", 32'(timeout), 32'd1);
        check("valid_close", 32'(valid), 32'd0);
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of GATE.
        sig_per = 30;
        run = 1'b1;
        wait_sig(0, 200, "wait_gate_5");
        repeat (10) @(posedge clk);
        #2 nRST = 1'b0;
        #1 check("rst_gate", 32'(gate), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_clear_n", 32'(clear_n), 32'd1);
        check("rst_store", 32'(store), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        repeat (3) @(negedge clk);
        #2 nRST = 1'b1;
        wait_sig(2, 5, "wait_clear_after_rst");
        run = 1'b0;
        wait_sig(1, 700, "wait_store_5");
        check("gate_len_after_rst", 32'(gate_len), 32'd120);
        check("valid_after_rst", 32'(valid), 32'd1);
        repeat (20) @(negedge clk);

        // Edge lands on the preset terminal count: window extends one period.
        sig_per = 100;
        repeat (5) @(negedge clk);
        pulse_run();
        wait_sig(1, 1200, "wait_store_6");
        check("gate_len_p100", 32'(gate_len), 32'd200);
        check("valid_6", 32'(valid), 32'd1);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
